bullcow_game_param: RTL and testbench
=====================================

Name: bullcow_game_param

Overview:
- Parametrised two-player Bulls & Cows engine; successor to the fixed 4-digit decimal game block.
- Generalised digit count, digit width, radix and score width.
- Adds internal enter edge detection, combinational validation of the live switch value, an invalid-entry pulse, a winner code and a turn counter.
- Sits between the board input layer (switches, debounced enter) and the display/score blocks.

Parameters:
- DIGITS, 4, digits per secret/guess; legal range 2..8.
- DIGIT_W, 4, bits per digit.
- RADIX, 10, digit values 0..RADIX-1; requires DIGITS <= RADIX <= 2**DIGIT_W.
- PTS_W, 8, width of each player's score counter.
- TURN_W, 8, width of the round counter.
- MAX_TURNS, 10, round limit; used only with MAX_TURNS_EN.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- enter  in  1  debounced confirm button (level); acted on at its rising edge.
- SW  in  DIGITS*DIGIT_W  digit i = SW[i*DIGIT_W +: DIGIT_W]; digit 0 in the LSBs.
- guess_confirmed  out  1  high after a valid guess until the next enter edge.
- input_error  out  1  one-cycle pulse on rejected entry.
- bull_count  out  $clog2(DIGITS+1)  bulls of the last valid guess.
- cow_count  out  $clog2(DIGITS+1)  cows of the last valid guess.
- game_state  out  3  current state encoding.
- winner  out  2  00 none, 01 J1, 10 J2, 11 draw.
- J1_points  out  PTS_W  J1 wins.
- J2_points  out  PTS_W  J2 wins.
- turn_count  out  TURN_W  completed rounds (J2 guesses) in the current game.

Behaviour:
- Reset (reset==0 at a clock edge) sets all of the following, and takes effect from any state:
  - state=J1_SETUP; secrets, counts, points, winner and turn_count = 0; guess_confirmed=0; input_error=0.
  - Edge register enter_q=1, so an enter held through reset release does not fire.
- Enter edge: enter_p = enter & ~enter_q; enter_q <= enter every cycle. A held enter gives exactly one action.
- Validation is combinational on live SW, not on a previously latched copy:
  - valid = every digit < RADIX AND all digit pairs distinct.
- Bulls/cows are combinational against the opponent's secret:
  - bull = digit i equals opp[i].
  - cow = digit i equals opp[j] for some j != i, and digit i is not a bull.
  - Distinct digits guarantee no double count; bulls+cows <= DIGITS.
- State encoding: J1_SETUP=000, J2_SETUP=001, J1_GUESS=010, J2_GUESS=011, END_GAME=111. Other codes go to J1_SETUP on the next cycle.
- Any enter_p clears guess_confirmed in that cycle unless the same edge sets it.
- Invalid enter_p in SETUP or GUESS states:
  - input_error=1 for one cycle.
  - State, secrets, counts and turn_count unchanged.
- Transitions on valid enter_p (one cycle latency; outputs update on the same edge as the state):
  - J1_SETUP: secret1 <= SW; next J2_SETUP.
  - J2_SETUP: secret2 <= SW; next J1_GUESS.
  - J1_GUESS (compared against secret2):
    - bull_count/cow_count registered; guess_confirmed=1.
    - bulls==DIGITS: winner=01, J1_points+1, next END_GAME.
    - Otherwise: next J2_GUESS.
  - J2_GUESS (compared against secret1):
    - bull_count/cow_count registered; guess_confirmed=1; turn_count+1 (saturating).
    - bulls==DIGITS: winner=10, J2_points+1, next END_GAME.
    - Otherwise: next J1_GUESS.
  - END_GAME: any enter_p (no validation; input_error stays 0):
    - Clears winner, counts, turn_count and secrets.
    - Next J1_SETUP; points retained.
- Point increments saturate at 2**PTS_W-1. A win at saturation still sets winner.
- Secrets are never placed on an output.

Optional Feature:
- Macro: BULLCOW_MAX_TURNS_EN.
- Defined: a non-winning valid J2_GUESS whose incremented turn_count equals MAX_TURNS:
  - Goes to END_GAME with winner=11 (draw).
  - Neither score changes.
  - bull_count/cow_count and guess_confirmed update as normal.
- Undefined: no round limit; turn_count saturates at 2**TURN_W-1; MAX_TURNS is ignored.

Test Plan:
- Reset then setup:
  - SW=0x1234, enter edge → game_state=001.
  - SW=0x5678 → 010.
  - No input_error pulse in either step.
- Invalid entries (defaults):
  - SW=0x1123 (repeat) → input_error for exactly one cycle; state stays 000.
  - SW=0x12A4 (digit ≥ RADIX) → same.
  - enter held 20 cycles → one action only.
- Scoring, secret2=0x5678, J1 guesses 0x5687 → bull_count=2, cow_count=2, guess_confirmed=1, state 011.
- J2 win, J2 guesses 0x1234 against secret1=0x1234:
  - state 111, winner=10, J2_points=1, turn_count=1.
  - Next enter → state 000, winner=00, J2_points still 1.
- Reset and saturation:
  - reset low mid-J2_GUESS → all outputs zero next cycle.
  - PTS_W=2: four J1 wins → J1_points stays 3.
- BULLCOW_MAX_TURNS_EN, MAX_TURNS=2:
  - Four non-winning valid guesses → state 111, winner=11, both scores 0, turn_count=2.

Source files
------------

// File: rtl/bullcow_game_param.sv
// Parametrised two-player Bulls & Cows engine.
// Each player enters a secret and then the players take turns guessing the
// opponent's secret. The live switch value is validated combinationally, and
// bulls and cows are computed by one comparator instance per digit.
// Optional build macro BULLCOW_MAX_TURNS_EN: when it is defined, a game that
// reaches MAX_TURNS completed rounds without a winner ends in a draw.

// Per-digit comparator. It compares guess digit IDX with every opponent digit
// and with the higher-indexed guess digits.
module bullcow_digit #(
  parameter int DIGITS  = 4,
  parameter int DIGIT_W = 4,
  parameter int RADIX   = 10,
  parameter int IDX     = 0
) (
  input  logic [DIGITS-1:0][DIGIT_W-1:0] guess,
  input  logic [DIGITS-1:0][DIGIT_W-1:0] opp,
  output logic                           bull,
  output logic                           cow,
  output logic                           in_range,
  output logic                           dup
);
  logic any_hit;

  // A bull is a positional match. A cow is a match at any other position
  // when the digit is not already a bull. Each duplicate pair is reported
  // only once, by the lower index.
  always_comb begin
    any_hit  = 1'b0;
    dup      = 1'b0;
    bull     = (guess[IDX] == opp[IDX]);
    in_range = (int'(guess[IDX]) < RADIX);
    for (int j = 0; j < DIGITS; j++) begin
      if (j != IDX && guess[IDX] == opp[j]) any_hit = 1'b1;
      if (j > IDX && guess[IDX] == guess[j]) dup = 1'b1;
    end
    cow = any_hit & ~bull;
  end
endmodule

module bullcow_game_param #(
  parameter int DIGITS    = 4,
  parameter int DIGIT_W   = 4,
  parameter int RADIX     = 10,
  parameter int PTS_W     = 8,
  parameter int TURN_W    = 8,
  parameter int MAX_TURNS = 10
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        enter,
  input  logic [DIGITS*DIGIT_W-1:0]   SW,
  output logic                        guess_confirmed,
  output logic                        input_error,
  output logic [$clog2(DIGITS+1)-1:0] bull_count,
  output logic [$clog2(DIGITS+1)-1:0] cow_count,
  output logic [2:0]                  game_state,
  output logic [1:0]                  winner,
  output logic [PTS_W-1:0]            J1_points,
  output logic [PTS_W-1:0]            J2_points,
  output logic [TURN_W-1:0]           turn_count
);
  localparam int CNT_W = $clog2(DIGITS+1);

  typedef enum logic [2:0] {
    J1_SETUP = 3'b000,
    J2_SETUP = 3'b001,
    J1_GUESS = 3'b010,
    J2_GUESS = 3'b011,
    END_GAME = 3'b111
  } state_t;

  typedef struct packed {
    state_t                        state;
    logic                          enter_q;
    logic [DIGITS-1:0][DIGIT_W-1:0] secret1;
    logic [DIGITS-1:0][DIGIT_W-1:0] secret2;
    logic [CNT_W-1:0]              bulls;
    logic [CNT_W-1:0]              cows;
    logic                          gc;
    logic                          ie;
    logic [1:0]                    winner;
    logic [PTS_W-1:0]              j1_pts;
    logic [PTS_W-1:0]              j2_pts;
    logic [TURN_W-1:0]             turn;
  } regs_t;

  // This generate block is empty. Its name appears in the hierarchy when the
  // parameter set is outside the supported range.
  if (DIGITS < 2 || DIGITS > 8 || RADIX < DIGITS || RADIX > 2**DIGIT_W ||
      MAX_TURNS < 1) begin : g_cfg_out_of_range
  end

  regs_t r_q, r_d;

  logic [DIGITS-1:0][DIGIT_W-1:0] sw_d, opp;
  logic [DIGITS-1:0]              bull_v, cow_v, rng_v, dup_v;
  logic [CNT_W-1:0]               nb, nc;
  logic                           enter_p, valid, win;
  logic [TURN_W-1:0]              turn_inc;

  assign sw_d    = SW;
  assign enter_p = enter & ~r_q.enter_q;
  // J1 guesses against J2's secret. Every other state uses J1's secret.
  assign opp     = (r_q.state == J1_GUESS) ? r_q.secret2 : r_q.secret1;

  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    bullcow_digit #(
      .DIGITS(DIGITS), .DIGIT_W(DIGIT_W), .RADIX(RADIX), .IDX(i)
    ) u_dig (
      .guess(sw_d), .opp(opp),
      .bull(bull_v[i]), .cow(cow_v[i]), .in_range(rng_v[i]), .dup(dup_v[i])
    );
  end

  // Reduce the per-digit flags to counts and the entry-valid flag.
  always_comb begin
    nb = '0;
    nc = '0;
    for (int i = 0; i < DIGITS; i++) begin
      nb = nb + CNT_W'(bull_v[i]);
      nc = nc + CNT_W'(cow_v[i]);
    end
    valid    = (&rng_v) & ~(|dup_v);
    win      = (nb == CNT_W'(DIGITS));
    turn_inc = (&r_q.turn) ? r_q.turn : r_q.turn + 1'b1;
  end

  // State register. Reset arms enter_q so that an enter held through reset
  // release does not fire.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_q         <= '0;
      r_q.enter_q <= 1'b1;
    end else begin
      r_q <= r_d;
    end
  end

  // Next-state and output logic. The outputs are registered, so they change
  // on the same edge as the state.
  always_comb begin
    r_d         = r_q;
    r_d.enter_q = enter;
    r_d.ie      = 1'b0;
    if (enter_p) r_d.gc = 1'b0;
    case (r_q.state)
      J1_SETUP: if (enter_p) begin
        if (valid) begin
          r_d.secret1 = sw_d;
          r_d.state   = J2_SETUP;
        end else r_d.ie = 1'b1;
      end
      J2_SETUP: if (enter_p) begin
        if (valid) begin
          r_d.secret2 = sw_d;
          r_d.state   = J1_GUESS;
        end else r_d.ie = 1'b1;
      end
      J1_GUESS: if (enter_p) begin
        if (valid) begin
          r_d.bulls = nb;
          r_d.cows  = nc;
          r_d.gc    = 1'b1;
          if (win) begin
            r_d.winner = 2'b01;
            if (!(&r_q.j1_pts)) r_d.j1_pts = r_q.j1_pts + 1'b1;
            r_d.state = END_GAME;
          end else r_d.state = J2_GUESS;
        end else r_d.ie = 1'b1;
      end
      J2_GUESS: if (enter_p) begin
        if (valid) begin
          r_d.bulls = nb;
          r_d.cows  = nc;
          r_d.gc    = 1'b1;
          r_d.turn  = turn_inc;
          if (win) begin
            r_d.winner = 2'b10;
            if (!(&r_q.j2_pts)) r_d.j2_pts = r_q.j2_pts + 1'b1;
            r_d.state = END_GAME;
          end
`ifdef BULLCOW_MAX_TURNS_EN
          else if (turn_inc == TURN_W'(MAX_TURNS)) begin
            r_d.winner = 2'b11;
            r_d.state  = END_GAME;
          end
`endif
          else r_d.state = J1_GUESS;
        end else r_d.ie = 1'b1;
      end
      END_GAME: if (enter_p) begin
        r_d.winner  = 2'b00;
        r_d.bulls   = '0;
        r_d.cows    = '0;
        r_d.turn    = '0;
        r_d.secret1 = '0;
        r_d.secret2 = '0;
        r_d.state   = J1_SETUP;
      end
      default: r_d.state = J1_SETUP;
    endcase
  end

  assign guess_confirmed = r_q.gc;
  assign input_error     = r_q.ie;
  assign bull_count      = r_q.bulls;
  assign cow_count       = r_q.cows;
  assign game_state      = r_q.state;
  assign winner          = r_q.winner;
  assign J1_points       = r_q.j1_pts;
  assign J2_points       = r_q.j2_pts;
  assign turn_count      = r_q.turn;
endmodule

// File: tb/tb_bullcow_game_param.sv
// Directed bench for bullcow_game_param. Instance A uses the default
// parameters, B uses PTS_W=2 to exercise score saturation, and C (built only
// when BULLCOW_MAX_TURNS_EN is defined) uses MAX_TURNS=2.
module tb_bullcow_game_param;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enter = 1'b0;
  logic [15:0] SW    = '0;

  logic       a_gc, a_ie, b_gc, b_ie;
  logic [2:0] a_bc, a_cc, a_st, b_bc, b_cc, b_st;
  logic [1:0] a_win, b_win;
  logic [7:0] a_p1, a_p2, a_turn, b_turn;
  logic [1:0] b_p1, b_p2;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clock = ~clock;

  bullcow_game_param u_a (
    .clock(clock), .reset(reset), .enter(enter), .SW(SW),
    .guess_confirmed(a_gc), .input_error(a_ie), .bull_count(a_bc),
    .cow_count(a_cc), .game_state(a_st), .winner(a_win),
    .J1_points(a_p1), .J2_points(a_p2), .turn_count(a_turn)
  );

  bullcow_game_param #(.PTS_W(2)) u_b (
    .clock(clock), .reset(reset), .enter(enter), .SW(SW),
    .guess_confirmed(b_gc), .input_error(b_ie), .bull_count(b_bc),
    .cow_count(b_cc), .game_state(b_st), .winner(b_win),
    .J1_points(b_p1), .J2_points(b_p2), .turn_count(b_turn)
  );

`ifdef BULLCOW_MAX_TURNS_EN
  logic       c_gc, c_ie;
  logic [2:0] c_bc, c_cc, c_st;
  logic [1:0] c_win;
  logic [7:0] c_p1, c_p2, c_turn;
  bullcow_game_param #(.MAX_TURNS(2)) u_c (
    .clock(clock), .reset(reset), .enter(enter), .SW(SW),
    .guess_confirmed(c_gc), .input_error(c_ie), .bull_count(c_bc),
    .cow_count(c_cc), .game_state(c_st), .winner(c_win),
    .J1_points(c_p1), .J2_points(c_p2), .turn_count(c_turn)
  );
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One enter pulse. On return the edge's result is visible, including a
  // possible one-cycle input_error.
  task automatic press(input logic [15:0] v);
    @(negedge clock);
    SW    = v;
    enter = 1'b1;
    @(negedge clock);
    enter = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    enter = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  initial begin
    do_reset();
    chk("rst_state", 32'(a_st), 32'h0);
    chk("rst_winner", 32'(a_win), 32'h0);
    chk("rst_p1", 32'(a_p1), 32'h0);
    chk("rst_p2", 32'(a_p2), 32'h0);
    chk("rst_turn", 32'(a_turn), 32'h0);
    chk("rst_gc", 32'(a_gc), 32'h0);
    chk("rst_ie", 32'(a_ie), 32'h0);
    chk("rst_bc", 32'({a_bc, a_cc}), 32'h0);

    // A repeated digit is rejected with a single-cycle pulse.
    press(16'h1123);
    chk("dup_ie", 32'(a_ie), 32'h1);
    chk("dup_state", 32'(a_st), 32'h0);
    @(negedge clock);
    chk("dup_ie_off", 32'(a_ie), 32'h0);

    // A digit value of RADIX or above is rejected in the same way.
    press(16'h12A4);
    chk("rng_ie", 32'(a_ie), 32'h1);
    chk("rng_state", 32'(a_st), 32'h0);
    @(negedge clock);
    chk("rng_ie_off", 32'(a_ie), 32'h0);

    // Holding enter for 20 cycles gives exactly one action.
    @(negedge clock);
    SW    = 16'h1234;
    enter = 1'b1;
    repeat (20) @(negedge clock);
    chk("hold_state", 32'(a_st), 32'h1);
    chk("hold_ie", 32'(a_ie), 32'h0);
    enter = 1'b0;
    @(negedge clock);

    press(16'h5678);
    chk("s2_state", 32'(a_st), 32'h2);
    chk("s2_ie", 32'(a_ie), 32'h0);

    // J1 guesses 5687 against 5678: two bulls and two cows.
    press(16'h5687);
    chk("g1_bull", 32'(a_bc), 32'h2);
    chk("g1_cow", 32'(a_cc), 32'h2);
    chk("g1_gc", 32'(a_gc), 32'h1);
    chk("g1_state", 32'(a_st), 32'h3);

    // An invalid guess keeps the counts but clears guess_confirmed.
    press(16'h5587);
    chk("g2inv_ie", 32'(a_ie), 32'h1);
    chk("g2inv_state", 32'(a_st), 32'h3);
    chk("g2inv_counts", 32'({a_bc, a_cc}), 32'({3'd2, 3'd2}));
    chk("g2inv_gc", 32'(a_gc), 32'h0);

    // J2 wins on its first guess.
    press(16'h1234);
    chk("j2w_state", 32'(a_st), 32'h7);
    chk("j2w_winner", 32'(a_win), 32'h2);
    chk("j2w_p2", 32'(a_p2), 32'h1);
    chk("j2w_turn", 32'(a_turn), 32'h1);
    chk("j2w_bull", 32'(a_bc), 32'h4);
    chk("j2w_gc", 32'(a_gc), 32'h1);

    press(16'h0000);
    chk("end_state", 32'(a_st), 32'h0);
    chk("end_winner", 32'(a_win), 32'h0);
    chk("end_p2", 32'(a_p2), 32'h1);
    chk("end_turn", 32'(a_turn), 32'h0);
    chk("end_bull", 32'(a_bc), 32'h0);
    chk("end_gc", 32'(a_gc), 32'h0);
    chk("end_ie", 32'(a_ie), 32'h0);

    // Reset in the middle of J2_GUESS.
    press(16'h1234);
    press(16'h5678);
    press(16'h5687);
    chk("mid_state", 32'(a_st), 32'h3);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("mid_rst_state", 32'(a_st), 32'h0);
    chk("mid_rst_p2", 32'(a_p2), 32'h0);
    chk("mid_rst_gc", 32'(a_gc), 32'h0);
    chk("mid_rst_counts", 32'({a_bc, a_cc}), 32'h0);
    reset = 1'b1;
    @(negedge clock);

    // Four J1 wins: the 2-bit score saturates at 3.
    for (int g = 0; g < 4; g++) begin
      press(16'h1234);
      press(16'h5678);
      press(16'h5678);
      chk("sat_winner", 32'(b_win), 32'h1);
      press(16'h0000);
    end
    chk("sat_b_p1", 32'(b_p1), 32'h3);
    chk("sat_a_p1", 32'(a_p1), 32'h4);
    chk("sat_state", 32'(b_st), 32'h0);

`ifdef BULLCOW_MAX_TURNS_EN
    do_reset();
    press(16'h1234);
    press(16'h5678);
    press(16'h5687);
    press(16'h5687);
    chk("mt_turn1", 32'(c_turn), 32'h1);
    press(16'h5687);
    press(16'h4321);
    chk("mt_state", 32'(c_st), 32'h7);
    chk("mt_winner", 32'(c_win), 32'h3);
    chk("mt_p1", 32'(c_p1), 32'h0);
    chk("mt_p2", 32'(c_p2), 32'h0);
    chk("mt_turn", 32'(c_turn), 32'h2);
    chk("mt_cow", 32'(c_cc), 32'h4);
    chk("mt_gc", 32'(c_gc), 32'h1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
